// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: request packet layout,
// operation encoding and arbiter FSM state constants.
package mem_port_arbiter_pkg;

    localparam int N_BITS    = 32;
    localparam int ADDR_BITS = 32;
    localparam int LEN_BITS  = 4;

    typedef enum logic {
        MEM_READ  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_op_t;

    typedef struct packed {
        mem_op_t               mtype;
        logic [ADDR_BITS-1:0]  addr;
        logic [LEN_BITS-1:0]   len;
        logic [N_BITS-1:0]     data;
    } mem_pkt_t;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE      = 2'd0;
    localparam arb_state_t ST_ISSUE     = 2'd1;
    localparam arb_state_t ST_WAIT_RESP = 2'd2;

    // Round-robin successor of a requester index.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request bit
// found searching upward from ptr, wrapping past the top index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = IDX_W'((32'(ptr) + 32'(i)) % 32'(NUM_REQ));
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                gnt[w_idx]   = 1'b1;
                gnt_idx      = w_idx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory request/response port between NUM_REQ requesters with
// round-robin arbitration and a single outstanding transaction.
//
// state        | meaning
// ST_IDLE      | no transaction; grant a requester if any is valid
// ST_ISSUE     | mem_req held on the memory side until mem_req_rdy
// ST_WAIT_RESP | request accepted; steer the response to the owner
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int N_BITS  = mem_port_arbiter_pkg::N_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_vld,
    input  mem_pkt_t [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0]   req_rdy,
    output logic [NUM_REQ-1:0]   resp_vld,
    output logic [N_BITS-1:0]    resp_data,
    output logic                 mem_req_vld,
    input  logic                 mem_req_rdy,
    output mem_pkt_t             mem_req,
    input  logic                 mem_resp_vld,
    input  logic [N_BITS-1:0]    mem_resp_data,
    output logic                 proto_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_owner;
    mem_pkt_t         r_mem_req;
    logic             r_proto_err;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic               w_any_req;
    logic               w_grant;
    logic               w_resp_done;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req_vld),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_any_req   = |req_vld;
    assign w_grant     = (r_state == ST_IDLE) && w_any_req;
    assign w_resp_done = (r_state == ST_WAIT_RESP) && mem_resp_vld;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_any_req)    w_state_nxt = ST_ISSUE;
            ST_ISSUE:     if (mem_req_rdy)  w_state_nxt = ST_WAIT_RESP;
            ST_WAIT_RESP: if (mem_resp_vld) w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_owner     <= '0;
            r_mem_req   <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_mem_req <= req[w_gnt_idx];
                r_owner   <= w_gnt_idx;
            end
            // Pointer only advances on completion so a dropped transaction
            // does not cost the owner its turn.
            if (w_resp_done) begin
                r_rr_ptr <= IDX_W'(next_idx(32'(r_owner), NUM_REQ));
            end
            if (mem_resp_vld && (r_state != ST_WAIT_RESP)) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    always_comb begin
        resp_vld = '0;
        if (w_resp_done) begin
            resp_vld[r_owner] = 1'b1;
        end
    end

    assign req_rdy     = w_grant ? w_gnt : '0;
    assign mem_req_vld = (r_state == ST_ISSUE);
    assign mem_req     = r_mem_req;
    assign resp_data   = mem_resp_data;
    assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven transactions,
// hand-written corner sequences and randomized traffic against a model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_vld;
    mem_pkt_t [1:0]  req;
    logic [1:0]      req_rdy;
    logic [1:0]      resp_vld;
    logic [31:0]     resp_data;
    logic            mem_req_vld;
    logic            mem_req_rdy;
    mem_pkt_t        mem_req;
    logic            mem_resp_vld;
    logic [31:0]     mem_resp_data;
    logic            proto_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic     pend [2];
    mem_pkt_t pend_pkt [2];
    int       model_ptr;

    typedef struct {
        logic [1:0] mask;
        int         bp;
        int         dly;
        int         exp_g;
    } vec_t;

    vec_t tbl [10];

    mem_port_arbiter #(.NUM_REQ(2), .N_BITS(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_vld       (req_vld),
        .req           (req),
        .req_rdy       (req_rdy),
        .resp_vld      (resp_vld),
        .resp_data     (resp_data),
        .mem_req_vld   (mem_req_vld),
        .mem_req_rdy   (mem_req_rdy),
        .mem_req       (mem_req),
        .mem_resp_vld  (mem_resp_vld),
        .mem_resp_data (mem_resp_data),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int g);
        return (g < 0) ? 2'b00 : (2'b01 << g);
    endfunction

    // Winner = pending requester at the smallest rotational distance from the pointer.
    function automatic int model_pick();
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = 2;
        for (int i = 0; i < 2; i++) begin
            if (pend[i]) begin
                d = (i - model_ptr + 2) % 2;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic mem_pkt_t pkt_for(input int i, input int r);
        mem_pkt_t p;
        p.mtype = (i == 0) ? MEM_READ : MEM_WRITE;
        p.addr  = 32'((i + 1) * 32'h100 + r * 32'h10);
        p.len   = 4'(r);
        p.data  = 32'hD000_0000 | 32'(r << 4) | 32'(i);
        return p;
    endfunction

    function automatic mem_pkt_t rand_pkt();
        mem_pkt_t p;
        p.mtype = mem_op_t'($urandom_range(0, 1));
        p.addr  = $urandom;
        p.len   = 4'($urandom_range(0, 15));
        p.data  = $urandom;
        return p;
    endfunction

    task automatic post(input int i, input mem_pkt_t p);
        pend[i]     = 1'b1;
        pend_pkt[i] = p;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 2; i++) begin
            req_vld[i] = pend[i];
            req[i]     = pend_pkt[i];
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " req_rdy"},     req_rdy,     2'b00);
        chk({tag, " mem_req_vld"}, mem_req_vld, 1'b0);
        chk({tag, " mem_req"},     mem_req,     '0);
        chk({tag, " resp_vld"},    resp_vld,    2'b00);
        chk({tag, " proto_err"},   proto_err,   1'b0);
    endtask

    // Entered just after a rising edge with the DUT in IDLE; returns likewise.
    task automatic run_txn(input int bp, input int dly, input int exp_g, input string tag);
        mem_pkt_t    exp_pkt;
        logic [31:0] rd;
        drive_reqs();
        mem_req_rdy  = 1'b0;
        mem_resp_vld = 1'b0;
        @(negedge clk);
        chk({tag, " grant"},           req_rdy,     oh(exp_g));
        chk({tag, " idle mem_req_vld"}, mem_req_vld, 1'b0);
        if (req_rdy == 2'b00) begin
            @(posedge clk); #1;
            return;
        end
        exp_pkt = pend_pkt[exp_g];
        @(posedge clk); #1;
        pend[exp_g] = 1'b0;
        drive_reqs();
        for (int c = 0; c <= bp; c++) begin
            mem_req_rdy = (c == bp);
            @(negedge clk);
            chk({tag, " issue mem_req_vld"}, mem_req_vld, 1'b1);
            chk({tag, " issue mem_req"},     mem_req,     exp_pkt);
            chk({tag, " issue req_rdy"},     req_rdy,     2'b00);
            @(posedge clk); #1;
        end
        mem_req_rdy = 1'b0;
        for (int c = 0; c <= dly; c++) begin
            rd            = $urandom;
            mem_resp_vld  = (c == dly);
            mem_resp_data = rd;
            @(negedge clk);
            chk({tag, " resp_vld"},         resp_vld,    (c == dly) ? oh(exp_g) : 2'b00);
            chk({tag, " resp_data"},        resp_data,   rd);
            chk({tag, " wait req_rdy"},     req_rdy,     2'b00);
            chk({tag, " wait mem_req_vld"}, mem_req_vld, 1'b0);
            @(posedge clk); #1;
        end
        mem_resp_vld = 1'b0;
        model_ptr    = (exp_g + 1) % 2;
    endtask

    initial begin
        tbl[0] = '{2'b11, 0, 0, 0};
        tbl[1] = '{2'b10, 1, 2, 1};
        tbl[2] = '{2'b10, 5, 0, 1};
        tbl[3] = '{2'b10, 0, 1, 1};
        tbl[4] = '{2'b10, 0, 0, 1};
        tbl[5] = '{2'b01, 2, 0, 0};
        tbl[6] = '{2'b01, 0, 3, 0};
        tbl[7] = '{2'b11, 0, 0, 1};
        tbl[8] = '{2'b11, 0, 0, 0};
        tbl[9] = '{2'b10, 0, 0, 1};

        rst           = 1'b1;
        req_vld       = 2'b00;
        req           = '0;
        mem_req_rdy   = 1'b0;
        mem_resp_vld  = 1'b0;
        mem_resp_data = '0;
        model_ptr     = 0;
        for (int i = 0; i < 2; i++) begin
            pend[i]     = 1'b0;
            pend_pkt[i] = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 2; i++) begin
                if (tbl[r].mask[i] && !pend[i]) post(i, pkt_for(i, r));
            end
            run_txn(tbl[r].bp, tbl[r].dly, tbl[r].exp_g, $sformatf("row%0d", r));
        end

        @(negedge clk);
        chk("proto_err before spurious", proto_err, 1'b0);
        @(posedge clk); #1;

        // Spurious response while idle must be dropped and flagged.
        drive_reqs();
        mem_resp_vld  = 1'b1;
        mem_resp_data = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("spurious resp_vld", resp_vld, 2'b00);
        @(posedge clk); #1;
        mem_resp_vld = 1'b0;
        @(negedge clk);
        chk("spurious proto_err", proto_err, 1'b1);
        chk("spurious mem_req_vld", mem_req_vld, 1'b0);
        @(posedge clk); #1;

        post(0, rand_pkt());
        run_txn(1, 1, model_pick(), "after_spurious");
        @(negedge clk);
        chk("proto_err sticky", proto_err, 1'b1);
        @(posedge clk); #1;

        // Pointer now favours req1; reset in WAIT_RESP must bring it back to req0.
        post(1, rand_pkt());
        drive_reqs();
        @(negedge clk);
        chk("pre_rst grant", req_rdy, 2'b10);
        @(posedge clk); #1;
        pend[1] = 1'b0;
        drive_reqs();
        mem_req_rdy = 1'b1;
        @(negedge clk);
        chk("pre_rst mem_req_vld", mem_req_vld, 1'b1);
        @(posedge clk); #1;
        mem_req_rdy = 1'b0;
        @(negedge clk);
        chk("pre_rst resp_vld", resp_vld, 2'b00);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst           = 1'b0;
        mem_resp_vld  = 1'b1;
        mem_resp_data = 32'h1A7E_0000;
        pend[0]       = 1'b0;
        pend[1]       = 1'b0;
        model_ptr     = 0;
        @(negedge clk);
        chk_reset_outputs("rst_wait");
        @(posedge clk); #1;
        mem_resp_vld = 1'b0;
        @(negedge clk);
        chk("late_resp proto_err", proto_err, 1'b1);
        @(posedge clk); #1;
        post(0, rand_pkt());
        post(1, rand_pkt());
        run_txn(0, 0, 0, "post_rst");

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) post(i, rand_pkt());
            end
            if (!pend[0] && !pend[1]) post(int'($urandom_range(0, 1)), rand_pkt());
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), model_pick(),
                    $sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
